// File: rtl/vga_timing_decoder.sv
// VGA timing recovery: samples active-low HSYNC/VSYNC, rebuilds the pixel and
// line counters, measures line/frame periods and sync widths, and tracks lock.
module vga_timing_decoder #(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter logic [10:0] CNT_MAX     = 11'd2047
) (
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [10:0] hc_rec,
  output logic [10:0] vc_rec,
  output logic [10:0] h_total,
  output logic [10:0] v_total,
  output logic [10:0] hs_width,
  output logic [10:0] vs_width,
  output logic        locked,
  output logic        frame_start,
  output logic        timing_err
);

  localparam logic [3:0] LockTarget = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    StSearch,
    StVerify,
    StLocked
  } state_e;

  state_e      state_q;
  logic        hs_r_q, hs_d_q, vs_r_q, vs_d_q;
  logic [10:0] hc_q, vc_q;
  logic [10:0] h_total_q, v_total_q, hs_width_q, vs_width_q;
  logic [10:0] v_ref_q;
  logic [3:0]  match_q;
  logic [1:0]  hv_cnt_q;
  logic        line_bad_q;
  logic        locked_q, frame_start_q, timing_err_q;

  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic        hc_sat, vc_sat, cnt_sat;
  logic [10:0] hc_inc;
  logic [10:0] v_total_new;
  logic [3:0]  match_inc;
  logic        line_bad_set, line_bad_eff;
  logic        lock_err, verify_abort, to_search;

  // Two-stage input sampling; the second stage gives the previous level for edge detection.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      hs_r_q <= 1'b0;
      hs_d_q <= 1'b0;
      vs_r_q <= 1'b0;
      vs_d_q <= 1'b0;
    end else begin
      hs_r_q <= hs_in;
      hs_d_q <= hs_r_q;
      vs_r_q <= vs_in;
      vs_d_q <= vs_r_q;
    end
  end

  // Edge decode, measurement arithmetic and lock-loss conditions.
  always_comb begin
    hs_fall      = hs_d_q & ~hs_r_q;
    hs_rise      = ~hs_d_q & hs_r_q;
    vs_fall      = vs_d_q & ~vs_r_q;
    vs_rise      = ~vs_d_q & vs_r_q;
    hc_sat       = (hc_q == CNT_MAX);
    vc_sat       = (vc_q == CNT_MAX);
    cnt_sat      = hc_sat | vc_sat;
    hc_inc       = hc_q + 11'd1;
    // VSYNC may land on the same clock as the HSYNC fall that would have counted this line.
    v_total_new  = vc_q + {10'd0, hs_fall};
    match_inc    = match_q + 4'd1;
    line_bad_set = hs_fall && (hv_cnt_q >= 2'd2) && (hc_inc != h_total_q);
    line_bad_eff = line_bad_q | line_bad_set;
    lock_err     = (state_q == StLocked) &&
                   ((line_bad_set && !line_bad_q) ||
                    (vs_fall && (v_total_new != v_ref_q)) ||
                    cnt_sat);
    verify_abort = (state_q == StVerify) && cnt_sat;
    to_search    = lock_err | verify_abort;
  end

  // Horizontal and vertical counters with their period/width measurements.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      hc_q       <= 11'd0;
      vc_q       <= 11'd0;
      h_total_q  <= 11'd0;
      v_total_q  <= 11'd0;
      hs_width_q <= 11'd0;
      vs_width_q <= 11'd0;
    end else begin
      if (hs_fall) begin
        h_total_q <= hc_inc;
        hc_q      <= 11'd0;
      end else if (!hc_sat) begin
        hc_q <= hc_inc;
      end
      if (hs_rise) begin
        hs_width_q <= hc_inc;
      end
      // A frame start takes priority over the line increment of a coincident HSYNC fall.
      if (vs_fall) begin
        v_total_q <= v_total_new;
        vc_q      <= 11'd0;
      end else if (hs_fall && !vc_sat) begin
        vc_q <= vc_q + 11'd1;
      end
      if (vs_rise) begin
        vs_width_q <= v_total_new;
      end
    end
  end

  // Line-length consistency check; the first two falls after SEARCH only prime h_total.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      hv_cnt_q   <= 2'd0;
      line_bad_q <= 1'b0;
    end else begin
      if (to_search) begin
        hv_cnt_q <= 2'd0;
      end else if (hs_fall && (hv_cnt_q != 2'd3)) begin
        hv_cnt_q <= hv_cnt_q + 2'd1;
      end
      if (vs_fall) begin
        line_bad_q <= 1'b0;
      end else if (line_bad_set) begin
        line_bad_q <= 1'b1;
      end
    end
  end

  // Lock state machine with registered status outputs.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      state_q       <= StSearch;
      match_q       <= 4'd0;
      v_ref_q       <= 11'd0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      timing_err_q  <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      timing_err_q  <= 1'b0;
      unique case (state_q)
        StSearch: begin
          locked_q <= 1'b0;
          if (vs_fall) begin
            state_q <= StVerify;
            match_q <= 4'd0;
            v_ref_q <= 11'd0;
          end
        end
        StVerify: begin
          if (verify_abort) begin
            state_q  <= StSearch;
            locked_q <= 1'b0;
          end else if (vs_fall) begin
            v_ref_q <= v_total_new;
            if (!line_bad_eff && (v_ref_q != 11'd0) && (v_total_new == v_ref_q)) begin
              match_q <= match_inc;
              if (match_inc == LockTarget) begin
                state_q  <= StLocked;
                locked_q <= 1'b1;
              end
            end else begin
              match_q <= 4'd0;
            end
          end
        end
        StLocked: begin
          if (vs_fall) begin
            frame_start_q <= 1'b1;
          end
          if (lock_err) begin
            timing_err_q <= 1'b1;
            state_q      <= StSearch;
            locked_q     <= 1'b0;
          end
        end
        default: begin
          state_q  <= StSearch;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign hc_rec      = hc_q;
  assign vc_rec      = vc_q;
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;
  assign hs_width    = hs_width_q;
  assign vs_width    = vs_width_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign timing_err  = timing_err_q;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Randomized-geometry VGA stream against a source-position model; expected
// observations are queued by the stimulus and consumed by a negedge monitor.
module tb_vga_timing_decoder;

  localparam int LF     = 2;
  localparam int CntMax = 2047;

  logic        clk_vga = 1'b0;
  logic        rst_n;
  logic        hs_in;
  logic        vs_in;
  logic [10:0] hc_rec, vc_rec, h_total, v_total, hs_width, vs_width;
  logic        locked, frame_start, timing_err;
  logic        probe;

  vga_timing_decoder #(
    .LOCK_FRAMES(LF),
    .CNT_MAX    (11'd2047)
  ) dut (
    .clk_vga    (clk_vga),
    .rst_n      (rst_n),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .hc_rec     (hc_rec),
    .vc_rec     (vc_rec),
    .h_total    (h_total),
    .v_total    (v_total),
    .hs_width   (hs_width),
    .vs_width   (vs_width),
    .locked     (locked),
    .frame_start(frame_start),
    .timing_err (timing_err)
  );

  always #5 clk_vga = ~clk_vga;

  typedef struct {
    string tag;
    int hc, vc, ht, hw, vt, vw, lk, fs, te;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Source geometry (scaled down so a full run stays short) and model state.
  int h_len, hs_w, v_len, vs_w, vs_off;
  int fs_cnt;   // frame starts generated since the last reset or loss of lock
  int rst_cnt;

  function automatic exp_t mk(string tag, int hc, int vc, int ht, int lk, int fs, int te);
    exp_t e;
    e.tag = tag; e.hc = hc; e.vc = vc; e.ht = ht;
    e.hw = hs_w; e.vt = v_len; e.vw = vs_w;
    e.lk = lk; e.fs = fs; e.te = te;
    return e;
  endfunction

  function automatic exp_t mk_zero();
    exp_t e;
    e.tag = "reset";
    e.hc = 0; e.vc = 0; e.ht = 0; e.hw = 0; e.vt = 0; e.vw = 0;
    e.lk = 0; e.fs = 0; e.te = 0;
    return e;
  endfunction

  // VSYNC is low from (line 0, vs_off) up to but excluding (line vs_w, vs_off).
  function automatic logic vs_level(int l, int s);
    bit in_win;
    in_win = (l > 0 || s >= vs_off) && (l < vs_w || (l == vs_w && s < vs_off));
    return !in_win;
  endfunction

  task automatic chk(string tag, string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s actual %0d expected %0d at %0t", tag, name, act, exp, $time);
    end
  endtask

  task automatic step(input logic hs, input logic vs);
    @(posedge clk_vga);
    #1;
    hs_in = hs;
    vs_in = vs;
    probe = 1'b0;
    if (rst_cnt > 0) begin
      exp_q.push_back(mk_zero());
      probe = 1'b1;
      rst_cnt--;
      if (rst_cnt == 0) rst_n = 1'b1;
    end
  endtask

  task automatic gen_frame(input int long_line, input int stop_line, input int stop_s,
                           input int rst_line, input int rst_s, input bit probes);
    int pl[3];
    int ps[3];
    for (int i = 0; i < 3; i++) begin
      pl[i] = $urandom_range(v_len - 1, 0);
      ps[i] = $urandom_range(h_len - 1, 4);
    end
    for (int l = 0; l < v_len; l++) begin
      int len;
      len = (l == long_line) ? h_len + 1 : h_len;
      for (int s = 0; s < len; s++) begin
        if (l == stop_line && s == stop_s) return;
        step(s >= hs_w, vs_level(l, s));
        if (l == 0 && s == 0) begin
          fs_cnt++;
          if (fs_cnt == LF + 2)
            exp_q.push_back(mk("lock", (vs_off != 0) ? 1 : 0, 0, h_len, 1, 0, 0));
          else if (fs_cnt > LF + 2)
            exp_q.push_back(mk("frame", (vs_off != 0) ? 1 : 0, 0, h_len, 1, 1, 0));
        end
        if (long_line >= 0 && l == long_line + 1 && s == 0 && fs_cnt >= LF + 2) begin
          exp_q.push_back(mk("long_line_err", 0, l, h_len + 1, 0, 0, 1));
          fs_cnt = 0;
        end
        if (l == rst_line && s == rst_s) begin
          rst_n   = 1'b0;
          rst_cnt = 3;
          fs_cnt  = 0;
        end
        if (probes && fs_cnt >= LF + 2 && rst_cnt == 0) begin
          bit hit;
          hit = 1'b0;
          for (int i = 0; i < 3; i++) if (l == pl[i] && s == ps[i]) hit = 1'b1;
          if (hit) begin
            exp_q.push_back(mk("align", s - 2, l, h_len, 1, 0, 0));
            probe = 1'b1;
          end
        end
      end
    end
  endtask

  // Monitor: any observable event pops the next expectation and compares all outputs.
  initial begin
    bit   lk_prev;
    bit   trig;
    exp_t e;
    lk_prev = 1'b0;
    forever begin
      @(negedge clk_vga);
      trig = probe || (frame_start === 1'b1) || (timing_err === 1'b1) ||
             ((locked === 1'b1) && !lk_prev);
      lk_prev = (locked === 1'b1);
      if (trig) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event fs=%0b te=%0b lk=%0b expected none at %0t",
                   frame_start, timing_err, locked, $time);
        end else begin
          e = exp_q.pop_front();
          chk(e.tag, "hc_rec", int'(hc_rec), e.hc);
          chk(e.tag, "vc_rec", int'(vc_rec), e.vc);
          chk(e.tag, "h_total", int'(h_total), e.ht);
          chk(e.tag, "hs_width", int'(hs_width), e.hw);
          chk(e.tag, "v_total", int'(v_total), e.vt);
          chk(e.tag, "vs_width", int'(vs_width), e.vw);
          chk(e.tag, "locked", int'(locked), e.lk);
          chk(e.tag, "frame_start", int'(frame_start), e.fs);
          chk(e.tag, "timing_err", int'(timing_err), e.te);
        end
      end
    end
  end

  initial begin
    h_len   = $urandom_range(90, 60);
    hs_w    = $urandom_range(20, 4);
    v_len   = $urandom_range(20, 12);
    vs_w    = $urandom_range(5, 2);
    vs_off  = 1;
    fs_cnt  = 0;
    rst_n   = 1'b0;
    hs_in   = 1'b1;
    vs_in   = 1'b1;
    probe   = 1'b0;
    rst_cnt = 3;
    $display("geometry h_len=%0d hs_w=%0d v_len=%0d vs_w=%0d", h_len, hs_w, v_len, vs_w);

    repeat (4) step(1'b1, 1'b1);

    // Lock on a clean stream, then aligned counters and one frame_start per frame.
    repeat (LF + 4) gen_frame(-1, -1, -1, -1, -1, 1'b1);

    // One over-long line while locked, then re-lock.
    gen_frame($urandom_range(v_len - 3, vs_w + 2), -1, -1, -1, -1, 1'b0);
    repeat (LF + 3) gen_frame(-1, -1, -1, -1, -1, 1'b1);

    // Stuck sync lines until the horizontal counter saturates, then resume.
    begin
      int l0;
      l0 = $urandom_range(v_len - 2, vs_w + 1);
      gen_frame(-1, l0, $urandom_range(h_len - 1, hs_w + 1), -1, -1, 1'b0);
      exp_q.push_back(mk("stuck_err", CntMax, l0, h_len, 0, 0, 1));
      fs_cnt = 0;
      repeat (2300) step(1'b1, 1'b1);
    end
    repeat (LF + 3) gen_frame(-1, -1, -1, -1, -1, 1'b1);

    // VSYNC falling on the same clock as HSYNC.
    vs_off = 0;
    repeat (2) gen_frame(-1, -1, -1, -1, -1, 1'b1);

    // Reset pulse in the middle of a frame, then re-lock.
    gen_frame(-1, -1, -1, $urandom_range(v_len - 2, 1), $urandom_range(h_len - 1, 0), 1'b0);
    repeat (LF + 3) gen_frame(-1, -1, -1, -1, -1, 1'b1);

    repeat (6) step(1'b1, 1'b1);
    chk("end", "pending_expectations", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
